// File: rtl/nmk_video_pkg.sv
// nmk_video_pkg: shared types and field layout for the NMK scroll/tilemap pipeline.
package nmk_video_pkg;
   typedef enum logic {IDLE, RUN} state_t;
   localparam int SCROLL_X_W   = 12;
   localparam int SCROLL_Y_W   = 9;
   localparam int MAP_ROW_W    = 5;
   localparam int MAP_COL_W    = 8;
   localparam int FLIPX_BIT    = 12;
   localparam int SCROLL_X_MSB = 11;
endpackage

// File: rtl/nmk_scroll_axis_cnt.sv
// nmk_scroll_axis_cnt: loadable wrapping up/down counter with enable.
module nmk_scroll_axis_cnt #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         down,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (!rst_n) q <= '0;
      else if (load) q <= load_val;
      else if (en) q <= down ? q - 1'b1 : q + 1'b1;
endmodule

// File: rtl/nmk_scroll_addr_gen.sv
// nmk_scroll_addr_gen: walks one scanline and emits tile-map address, fine offsets and tile fetch requests.
module nmk_scroll_addr_gen
   import nmk_video_pkg::*;
#(
   parameter int ACTIVE_W  = 256,
   parameter int TILE_BITS = 4
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           PIX_EN,
   input  logic                           LINE_START,
   input  logic [15:0]                    SCROLL_IN,
   input  logic [SCROLL_Y_W-1:0]          SCROLL_Y,
   input  logic [SCROLL_Y_W-1:0]          VPOS,
   output logic [MAP_ROW_W+MAP_COL_W-1:0] MAP_ADDR,
   output logic [TILE_BITS-1:0]           FINE_X,
   output logic [TILE_BITS-1:0]           FINE_Y,
   output logic                           PIX_VLD,
   output logic                           TILE_REQ,
   output logic                           LINE_DONE,
   output logic                           BUSY
);
   state_t                state;
   logic                  flip, first;
   logic [SCROLL_Y_W-1:0] ypos;
   logic [SCROLL_X_W-1:0] xpos, cnt;
   logic [TILE_BITS-1:0]  fx;
   logic                  step, last, tile_edge;
   logic                  scroll_unused;

   assign scroll_unused = ^SCROLL_IN[15:FLIPX_BIT+1];
   assign fx        = xpos[TILE_BITS-1:0];
   assign tile_edge = flip ? &fx : ~|fx;
   assign step      = state == RUN && PIX_EN && !LINE_START;
   assign last      = cnt == SCROLL_X_W'(ACTIVE_W - 1);
   assign BUSY      = state == RUN;

   nmk_scroll_axis_cnt #(.W(SCROLL_X_W)) u_xcnt (
      .clk      (CLK),
      .rst_n    (nRST),
      .load     (LINE_START),
      .load_val (SCROLL_IN[SCROLL_X_MSB:0]),
      .en       (step),
      .down     (flip),
      .q        (xpos)
   );

   // LINE_START wins over everything, including a coincident last pixel.
   always_ff @(posedge CLK)
      if (!nRST) begin
         state     <= IDLE;
         flip      <= 1'b0;
         first     <= 1'b0;
         ypos      <= '0;
         cnt       <= '0;
         MAP_ADDR  <= '0;
         FINE_X    <= '0;
         FINE_Y    <= '0;
         PIX_VLD   <= 1'b0;
         TILE_REQ  <= 1'b0;
         LINE_DONE <= 1'b0;
      end else if (LINE_START) begin
         state     <= RUN;
         flip      <= SCROLL_IN[FLIPX_BIT];
         first     <= 1'b1;
         ypos      <= VPOS + SCROLL_Y;
         cnt       <= '0;
         PIX_VLD   <= 1'b0;
         TILE_REQ  <= 1'b0;
         LINE_DONE <= 1'b0;
      end else begin
         PIX_VLD   <= step;
         TILE_REQ  <= step && (first || tile_edge);
         LINE_DONE <= step && last;
         if (step) begin
            MAP_ADDR <= {ypos[TILE_BITS +: MAP_ROW_W], xpos[TILE_BITS +: MAP_COL_W]};
            FINE_X   <= fx;
            FINE_Y   <= ypos[TILE_BITS-1:0];
            cnt      <= cnt + 1'b1;
            first    <= 1'b0;
            if (last) state <= IDLE;
         end
      end
endmodule
